// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Read hits return data combinationally; misses and stores stall until the memory handshake completes.
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR
    } state_t;

    state_t state, next_state;

    logic [SETS-1:0]          valid;
    logic [TAG_W-1:0]         tags  [SETS];
    logic [DATA_WIDTH-1:0]    lines [SETS];

    logic [ADDRESS_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0]    cap_wdata;

    logic [IDX_W-1:0] req_idx, cap_idx;
    logic [TAG_W-1:0] req_tag, cap_tag;
    logic             hit, cap_hit;
    logic             capture, fill, wr_update, count_hit, count_miss;

    assign req_idx = req_addr[2 +: IDX_W];
    assign req_tag = req_addr[ADDRESS_WIDTH-1 : 2+IDX_W];
    assign cap_idx = cap_addr[2 +: IDX_W];
    assign cap_tag = cap_addr[ADDRESS_WIDTH-1 : 2+IDX_W];

    assign hit     = req_valid & valid[req_idx] & (tags[req_idx] == req_tag) & !flush;
    assign cap_hit = valid[cap_idx] & (tags[cap_idx] == cap_tag);

    // Memory-side outputs come only from registers, never from req_*.
    assign mem_req   = (state != IDLE);
    assign mem_we    = (state == WR);
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        rd_data    = lines[req_idx];
        capture    = 1'b0;
        fill       = 1'b0;
        wr_update  = 1'b0;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        stall      = 1'b1;
                        capture    = 1'b1;
                        next_state = WR;
                    end else if (hit) begin
                        count_hit = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        capture    = 1'b1;
                        count_miss = 1'b1;
                        next_state = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                if (mem_ready) begin
                    rd_data    = mem_rdata;
                    fill       = !flush;
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            WR: begin
                if (mem_ready) begin
                    wr_update  = !flush & cap_hit;
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (count_hit)
                hit_count <= hit_count + 32'd1;
            if (count_miss)
                miss_count <= miss_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            valid <= '0;
        else if (fill)
            valid[cap_idx] <= 1'b1;
    end

    // Tag and data arrays carry no reset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[cap_idx]  <= cap_tag;
            lines[cap_idx] <= mem_rdata;
        end else if (wr_update) begin
            lines[cap_idx] <= cap_wdata;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache: hits, misses, stores, conflicts, flush and reset.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic [31:0] rd_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    data_cache #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .SETS         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .flush     (flush),
        .rd_data   (rd_data),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle before checking.
    task automatic cyc(input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] rdat, input logic fl);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        mem_ready = rdy;
        mem_rdata = rdat;
        flush     = fl;
        #1;
    endtask

    // Load miss answered on the first RD_MISS cycle.
    task automatic load_miss(input string tag, input logic [31:0] a, input logic [31:0] rdat);
        cyc(1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0, 1'b0);
        chk({tag, "_miss_stall"}, {31'b0, stall}, 32'd1);
        cyc(1'b1, 1'b0, a, 32'h0, 1'b1, rdat, 1'b0);
        chk({tag, "_ack_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_ack_data"}, rd_data, rdat);
        chk({tag, "_ack_addr"}, mem_addr, a);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);

        // Cold load miss, then a hit on the same address.
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t1_idle_stall", {31'b0, stall}, 32'd1);
        chk("t1_idle_mem_req", {31'b0, mem_req}, 32'd0);
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("t1_ack_stall", {31'b0, stall}, 32'd0);
        chk("t1_ack_data", rd_data, 32'hDEADBEEF);
        chk("t1_mem_req", {31'b0, mem_req}, 32'd1);
        chk("t1_mem_we", {31'b0, mem_we}, 32'd0);
        chk("t1_mem_addr", mem_addr, 32'h40);
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t1_hit_stall", {31'b0, stall}, 32'd0);
        chk("t1_hit_data", rd_data, 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t1_hits", hit_count, 32'd1);
        chk("t1_misses", miss_count, 32'd1);

        // Store hit with memory acknowledging after three waiting cycles.
        cyc(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0, 1'b0);
        chk("t2_idle_stall", {31'b0, stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0, 1'b0);
            chk("t2_wait_stall", {31'b0, stall}, 32'd1);
            chk("t2_mem_we", {31'b0, mem_we}, 32'd1);
        end
        chk("t2_mem_addr", mem_addr, 32'h40);
        chk("t2_mem_wdata", mem_wdata, 32'h12345678);
        cyc(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b1, 32'h0, 1'b0);
        chk("t2_ack_stall", {31'b0, stall}, 32'd0);
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t2_hit_stall", {31'b0, stall}, 32'd0);
        chk("t2_hit_data", rd_data, 32'h12345678);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t2_hits", hit_count, 32'd2);

        // Store miss must not allocate.
        cyc(1'b1, 1'b1, 32'h80, 32'h55AA55AA, 1'b0, 32'h0, 1'b0);
        chk("t3_idle_stall", {31'b0, stall}, 32'd1);
        cyc(1'b1, 1'b1, 32'h80, 32'h55AA55AA, 1'b1, 32'h0, 1'b0);
        chk("t3_mem_addr", mem_addr, 32'h80);
        chk("t3_ack_stall", {31'b0, stall}, 32'd0);
        load_miss("t3_load80", 32'h80, 32'hAAAA0080);

        // Conflicting tags in set 0 keep evicting each other.
        load_miss("t4_a", 32'h40, 32'h00000040);
        load_miss("t4_b", 32'h60, 32'h00000060);
        load_miss("t4_c", 32'h40, 32'h00000041);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t4_misses", miss_count, 32'd5);
        chk("t4_hits", hit_count, 32'd2);

        // Flush while idle, then flush during the fill acknowledge.
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t5_after_flush_stall", {31'b0, stall}, 32'd1);
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D, 1'b1);
        chk("t5_ack_stall", {31'b0, stall}, 32'd0);
        chk("t5_ack_data", rd_data, 32'hCAFEF00D);
        load_miss("t5_still_invalid", 32'h40, 32'hBEEF0040);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t5_misses", miss_count, 32'd7);

        // Reset in the middle of a read miss.
        cyc(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_idle_stall", {31'b0, stall}, 32'd1);
        cyc(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_rdmiss_mem_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_mem_req", {31'b0, mem_req}, 32'd0);
        chk("t6_mem_addr", mem_addr, 32'h0);
        chk("t6_hits", hit_count, 32'd0);
        chk("t6_misses", miss_count, 32'd0);
        load_miss("t6_line_invalid", 32'h40, 32'h0BADF00D);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_misses_after", miss_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
